// File: rtl/axil_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_reg_pkg
//  Description : Shared AXI4-Lite response codes and the write/read FSM state
//                types used by the register bank and its helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package axil_reg_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axil_wr_hold.sv
`default_nettype none
// ============================================================================
//  Module      : axil_wr_hold
//  Description : Single-entry holding slot for one AXI4-Lite write channel
//                (AW or W). Accepts a beat when empty and not blocked, holds
//                it until the write engine consumes it.
//  Ports       : clk/rst      - clock, synchronous active-high reset
//                i_valid/o_ready/i_data - upstream channel handshake + payload
//                i_block      - write response pending, refuse new beats
//                i_consume    - write engine has used the held beat
//                o_full/o_data - slot status and held payload
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_wr_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_block,
    input  logic             i_consume,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Ready is forced low during reset so the channel never handshakes
    // while the bank is being initialised.
    assign o_ready = !r_full && !i_block && !rst;
    assign o_full  = r_full;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_consume) begin
            r_full <= 1'b0;
        end else if (i_valid && o_ready) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axil_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : axil_reg_bank
//  Description : AXI4-Lite slave register bank. NUM_REGS registers of
//                DATA_WIDTH bits, byte-strobed writes, per-register read-only
//                mask (RO registers are loaded by hardware via hw_we/hw_din).
//  Ports       : ACLK/ARESET  - clock, synchronous active-high reset
//                S_AXI_*      - AXI4-Lite slave (AW, W, B, AR, R channels)
//                reg_q        - flat register contents, register i at slice i
//                hw_we/hw_din - hardware load strobes/data for RO registers
//                wr_pulse/rd_pulse - one-cycle per-register access strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_reg_bank
    import axil_reg_pkg::*;
#(
    parameter int                           DATA_WIDTH = 32,
    parameter int                           ADDR_WIDTH = 6,
    parameter int                           NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0]          RO_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS-1:0]            hw_we,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_din,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_LSB    = $clog2(c_STRB_W);
    localparam int c_IDX_W  = ADDR_WIDTH - c_LSB;

    wr_state_t r_wr_state, w_wr_state_nxt;
    rd_state_t r_rd_state, w_rd_state_nxt;

    logic                          w_aw_full, w_w_full, w_b_pend, w_do_write;
    logic [ADDR_WIDTH-1:0]         w_aw_addr;
    logic [c_STRB_W+DATA_WIDTH-1:0] w_w_slot;
    logic [c_STRB_W-1:0]           w_wstrb;
    logic [DATA_WIDTH-1:0]         w_wdata;
    logic [c_IDX_W-1:0]            w_aw_idx, w_ar_idx;
    logic [NUM_REGS-1:0]           w_aw_sel, w_ar_sel, w_wr_en;
    logic                          w_aw_ok, w_ar_hs;
    logic [DATA_WIDTH-1:0]         w_ar_data;

    logic [1:0]                    r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0]         r_rdata;
    logic [NUM_REGS-1:0]           r_wr_pulse, r_rd_pulse;

    logic                          w_unused;
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        w_aw_addr[c_LSB-1:0], S_AXI_ARADDR[c_LSB-1:0]};

    // ---------------- write channel holding slots -------------------------
    assign w_b_pend   = (r_wr_state == W_RESP);
    assign w_do_write = (r_wr_state == W_IDLE) && w_aw_full && w_w_full;

    axil_wr_hold #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
        .clk       (ACLK),
        .rst       (ARESET),
        .i_valid   (S_AXI_AWVALID),
        .o_ready   (S_AXI_AWREADY),
        .i_data    (S_AXI_AWADDR),
        .i_block   (w_b_pend),
        .i_consume (w_do_write),
        .o_full    (w_aw_full),
        .o_data    (w_aw_addr)
    );

    axil_wr_hold #(.WIDTH(c_STRB_W + DATA_WIDTH)) u_w_hold (
        .clk       (ACLK),
        .rst       (ARESET),
        .i_valid   (S_AXI_WVALID),
        .o_ready   (S_AXI_WREADY),
        .i_data    ({S_AXI_WSTRB, S_AXI_WDATA}),
        .i_block   (w_b_pend),
        .i_consume (w_do_write),
        .o_full    (w_w_full),
        .o_data    (w_w_slot)
    );

    assign w_wstrb = w_w_slot[c_STRB_W+DATA_WIDTH-1:DATA_WIDTH];
    assign w_wdata = w_w_slot[DATA_WIDTH-1:0];

    // ---------------- address decode ---------------------------------------
    // One-hot selects; an all-zero select means the index is out of range.
    assign w_aw_idx = w_aw_addr[ADDR_WIDTH-1:c_LSB];
    assign w_ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:c_LSB];
    assign w_ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;

    always_comb begin
        w_aw_sel  = '0;
        w_ar_sel  = '0;
        w_ar_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_aw_sel[i] = (w_aw_idx == c_IDX_W'(i));
            w_ar_sel[i] = (w_ar_idx == c_IDX_W'(i));
            if (w_ar_sel[i]) begin
                w_ar_data = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_aw_ok = |(w_aw_sel & ~RO_MASK);
    // An all-zero strobe still answers OKAY but touches nothing.
    assign w_wr_en = (w_do_write && (|w_wstrb)) ? (w_aw_sel & ~RO_MASK) : '0;

    // ---------------- register storage ------------------------------------
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_q;

        always_ff @(posedge ACLK) begin
            if (ARESET) begin
                r_q <= RESET_VAL[g*DATA_WIDTH +: DATA_WIDTH];
            end else if (RO_MASK[g] && hw_we[g]) begin
                r_q <= hw_din[g*DATA_WIDTH +: DATA_WIDTH];
            end else if (w_wr_en[g]) begin
                for (int b = 0; b < c_STRB_W; b++) begin
                    if (w_wstrb[b]) begin
                        r_q[8*b +: 8] <= w_wdata[8*b +: 8];
                    end
                end
            end
        end

        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = r_q;
    end

    // ---------------- FSMs -------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_state <= W_IDLE;
            r_rd_state <= R_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            W_IDLE: if (w_do_write)   w_wr_state_nxt = W_RESP;
            W_RESP: if (S_AXI_BREADY) w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_IDLE: if (w_ar_hs)      w_rd_state_nxt = R_DATA;
            R_DATA: if (S_AXI_RREADY) w_rd_state_nxt = R_IDLE;
        endcase
    end

    // ---------------- response / pulse registers ---------------------------
    // Read data is captured from the pre-edge register values, so a read
    // that collides with a write to the same register sees the old value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_bresp    <= AXI_RESP_OKAY;
            r_rresp    <= AXI_RESP_OKAY;
            r_rdata    <= '0;
            r_wr_pulse <= '0;
            r_rd_pulse <= '0;
        end else begin
            r_wr_pulse <= w_wr_en;
            r_rd_pulse <= w_ar_hs ? w_ar_sel : '0;
            if (w_do_write) begin
                r_bresp <= w_aw_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
            if (w_ar_hs) begin
                r_rdata <= w_ar_data;
                r_rresp <= (|w_ar_sel) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
        end
    end

    assign S_AXI_BVALID  = (r_wr_state == W_RESP);
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = (r_rd_state == R_IDLE) && !ARESET;
    assign S_AXI_RVALID  = (r_rd_state == R_DATA);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign wr_pulse      = r_wr_pulse;
    assign rd_pulse      = r_rd_pulse;

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_reg_bank
//  Description : Directed self-checking bench for axil_reg_bank: a 32-bit
//                instance (reg7 read-only, non-zero reset values) and a
//                64-bit instance with default parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_reg_bank;
    import axil_reg_pkg::*;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 8;
    localparam logic [NR-1:0]    c_RO  = 8'b1000_0000;
    localparam logic [NR*DW-1:0] c_RST = {32'h0000_0077, 32'h0, 32'h0, 32'h0,
                                          32'h0, 32'h0, 32'h0000_1111, 32'h0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] prot = 3'b000;

    // 32-bit instance signals
    logic [AW-1:0]    awaddr = '0, araddr = '0;
    logic             awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [DW-1:0]    wdata = '0;
    logic [DW/8-1:0]  wstrb = '0;
    logic             awready, wready, bvalid, arready, rvalid;
    logic [1:0]       bresp, rresp;
    logic [DW-1:0]    rdata;
    logic [NR*DW-1:0] reg_q;
    logic [NR*DW-1:0] hw_din = '0;
    logic [NR-1:0]    hw_we = '0, wr_pulse, rd_pulse;

    // 64-bit instance signals
    logic [AW-1:0]    awaddr_w = '0, araddr_w = '0;
    logic             awvalid_w = 0, wvalid_w = 0, bready_w = 0, arvalid_w = 0, rready_w = 0;
    logic [63:0]      wdata_w = '0;
    logic [7:0]       wstrb_w = '0;
    logic             awready_w, wready_w, bvalid_w, arready_w, rvalid_w;
    logic [1:0]       bresp_w, rresp_w;
    logic [63:0]      rdata_w;
    logic [NR*64-1:0] reg_q_w;
    logic [NR*64-1:0] hw_din_w = '0;
    logic [NR-1:0]    hw_we_w = '0, wr_pulse_w, rd_pulse_w;

    axil_reg_bank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
        .RO_MASK(c_RO), .RESET_VAL(c_RST)
    ) u_dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(prot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(prot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_q(reg_q), .hw_we(hw_we), .hw_din(hw_din), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    axil_reg_bank #(
        .DATA_WIDTH(64), .ADDR_WIDTH(AW), .NUM_REGS(NR)
    ) u_dut_w (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr_w), .S_AXI_AWPROT(prot), .S_AXI_AWVALID(awvalid_w), .S_AXI_AWREADY(awready_w),
        .S_AXI_WDATA(wdata_w), .S_AXI_WSTRB(wstrb_w), .S_AXI_WVALID(wvalid_w), .S_AXI_WREADY(wready_w),
        .S_AXI_BRESP(bresp_w), .S_AXI_BVALID(bvalid_w), .S_AXI_BREADY(bready_w),
        .S_AXI_ARADDR(araddr_w), .S_AXI_ARPROT(prot), .S_AXI_ARVALID(arvalid_w), .S_AXI_ARREADY(arready_w),
        .S_AXI_RDATA(rdata_w), .S_AXI_RRESP(rresp_w), .S_AXI_RVALID(rvalid_w), .S_AXI_RREADY(rready_w),
        .reg_q(reg_q_w), .hw_we(hw_we_w), .hw_din(hw_din_w), .wr_pulse(wr_pulse_w), .rd_pulse(rd_pulse_w)
    );

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt [NR];
    int rd_cnt [NR];

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (wr_pulse[i]) wr_cnt[i]++;
            if (rd_pulse[i]) rd_cnt[i]++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pulse_total();
        int s = 0;
        for (int i = 0; i < NR; i++) s += wr_cnt[i] + rd_cnt[i];
        return s;
    endfunction

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] s, input int stall, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int n = 0;
        logic bad = 1'b0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) begin awvalid = 0; aw_done = 1; end
            if (w_hs)  begin wvalid = 0;  w_done = 1;  end
            n++;
        end
        awvalid = 0; wvalid = 0;
        chk("wr_accept", {62'd0, aw_done, w_done}, 64'd3);
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        chk("bvalid_seen", bvalid, 1);
        resp = bresp;
        for (int k = 0; k < stall; k++) begin
            tick();
            if (bvalid !== 1'b1 || bresp !== resp || awready !== 1'b0 || wready !== 1'b0) bad = 1'b1;
        end
        if (stall > 0) chk("b_stall_stable", bad, 0);
        bready = 1; tick(); bready = 0;
        chk("b_done", bvalid, 0);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int stall,
                            output logic [DW-1:0] d, output logic [1:0] resp);
        bit hs_done = 0, hs;
        int n = 0;
        logic bad = 1'b0;
        araddr = a; arvalid = 1;
        while (!hs_done && n < 20) begin
            hs = arvalid && arready;
            tick();
            if (hs) hs_done = 1;
            n++;
        end
        arvalid = 0;
        chk("ar_accept", hs_done, 1);
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        chk("rvalid_seen", rvalid, 1);
        d = rdata; resp = rresp;
        for (int k = 0; k < stall; k++) begin
            tick();
            if (rvalid !== 1'b1 || rdata !== d || rresp !== resp || arready !== 1'b0) bad = 1'b1;
        end
        if (stall > 0) chk("r_stall_stable", bad, 0);
        rready = 1; tick(); rready = 0;
        chk("r_done", rvalid, 0);
    endtask

    task automatic wr64(input logic [AW-1:0] a, input logic [63:0] d, output logic [1:0] resp);
        int n = 0;
        awaddr_w = a; wdata_w = d; wstrb_w = 8'hFF; awvalid_w = 1; wvalid_w = 1;
        while (!(awready_w && wready_w) && n < 20) begin tick(); n++; end
        tick();
        awvalid_w = 0; wvalid_w = 0;
        n = 0;
        while (!bvalid_w && n < 20) begin tick(); n++; end
        chk("w64_bvalid", bvalid_w, 1);
        resp = bresp_w;
        bready_w = 1; tick(); bready_w = 0;
    endtask

    task automatic rd64(input logic [AW-1:0] a, output logic [63:0] d, output logic [1:0] resp);
        int n = 0;
        araddr_w = a; arvalid_w = 1;
        while (!arready_w && n < 20) begin tick(); n++; end
        tick();
        arvalid_w = 0;
        n = 0;
        while (!rvalid_w && n < 20) begin tick(); n++; end
        chk("r64_rvalid", rvalid_w, 1);
        d = rdata_w; resp = rresp_w;
        rready_w = 1; tick(); rready_w = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]       resp;
        logic [DW-1:0]    d;
        logic [63:0]      d64;
        int               c_wr [NR];
        int               c_rd [NR];
        int               tot;
        logic             bad;
        logic [NR*DW-1:0] snap;

        // ---------------- reset state ----------------
        rst = 1;
        repeat (3) tick();
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_valids", {bvalid, rvalid, bvalid_w, rvalid_w}, 0);
        chk("rst_resp_data", {bresp, rresp, rdata}, 0);
        chk("rst_pulses", {wr_pulse, rd_pulse}, 0);
        chk("rst_reg_q", reg_q == c_RST, 1);
        rst = 0;
        tick();
        chk("post_rst_ready", {awready, wready, arready}, 3'b111);

        // ---------------- W three cycles ahead of AW, partial strobe ------
        wvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'b0101;
        tick();
        wvalid = 0;
        chk("w_held_wready", wready, 0);
        tick(); tick();
        chk("no_b_before_aw", bvalid, 0);
        awaddr = 6'h08; awvalid = 1;
        tick();
        awvalid = 0;
        chk("b_not_at_aw_hs", bvalid, 0);
        tick();
        chk("bvalid_after_aw", bvalid, 1);
        chk("bresp_strb", bresp, AXI_RESP_OKAY);
        chk("reg2_strb", reg_q[95:64], 32'h00AD_00EF);
        chk("wr_pulse_reg2", wr_pulse, 8'h04);
        chk("aw_blocked_in_resp", {awready, wready}, 0);
        bready = 1; tick(); bready = 0;
        chk("b_cleared", bvalid, 0);

        // ---------------- basic write / read-back -------------------------
        for (int i = 0; i < NR; i++) begin c_wr[i] = wr_cnt[i]; c_rd[i] = rd_cnt[i]; end
        for (int i = 0; i < 4; i++) begin
            axi_write(AW'(i * 4), DW'(i + 1), 4'hF, 0, resp);
            chk("wr_okay", resp, AXI_RESP_OKAY);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(AW'(i * 4), 0, d, resp);
            chk("rd_data", d, 64'(i + 1));
            chk("rd_okay", resp, AXI_RESP_OKAY);
        end
        for (int i = 0; i < 4; i++) begin
            chk("wr_pulse_once", 64'(wr_cnt[i] - c_wr[i]), 1);
            chk("rd_pulse_once", 64'(rd_cnt[i] - c_rd[i]), 1);
        end

        // ---------------- read-only register -----------------------------
        c_wr[7] = wr_cnt[7];
        axi_write(6'h1C, 32'h55, 4'hF, 0, resp);
        chk("ro_wr_slverr", resp, AXI_RESP_SLVERR);
        chk("ro_unchanged", reg_q[255:224], 32'h77);
        chk("ro_no_pulse", 64'(wr_cnt[7] - c_wr[7]), 0);
        hw_din = '0;
        hw_din[255:224] = 32'hA5;
        hw_din[31:0]    = 32'hFFFF;
        hw_we = 8'h81;
        tick();
        hw_we = '0;
        chk("hw_load_ro", reg_q[255:224], 32'hA5);
        chk("hw_ignored_rw", reg_q[31:0], 32'h1);
        axi_read(6'h1C, 0, d, resp);
        chk("ro_read", d, 32'hA5);
        chk("ro_read_okay", resp, AXI_RESP_OKAY);

        // ---------------- out-of-range access -----------------------------
        tot  = pulse_total();
        snap = reg_q;
        axi_read(6'h20, 0, d, resp);
        chk("oor_rdata", d, 0);
        chk("oor_rresp", resp, AXI_RESP_SLVERR);
        axi_write(6'h20, 32'hFFFF_FFFF, 4'hF, 0, resp);
        chk("oor_bresp", resp, AXI_RESP_SLVERR);
        tick();
        chk("oor_no_pulses", 64'(pulse_total() - tot), 0);
        chk("oor_regs_same", reg_q == snap, 1);

        // ---------------- back-pressure on B and R ------------------------
        axi_write(6'h10, 32'hA1A2_A3A4, 4'hF, 10, resp);
        chk("stall_wr_okay", resp, AXI_RESP_OKAY);
        axi_read(6'h10, 10, d, resp);
        chk("stall_rd_data", d, 32'hA1A2_A3A4);

        // ---------------- write and read of same register collide ---------
        awaddr = 6'h0C; wdata = 32'h99; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        araddr = 6'h0C; arvalid = 1;
        tick();
        arvalid = 0;
        chk("collide_reg3_new", reg_q[127:96], 32'h99);
        chk("collide_rvalid", rvalid, 1);
        chk("collide_rd_old", rdata, 32'h4);
        rready = 1; bready = 1;
        tick();
        rready = 0; bready = 0;
        chk("collide_done", {bvalid, rvalid}, 0);

        // ---------------- reset during outstanding responses --------------
        awaddr = 6'h00; wdata = 32'h5A5A; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 6'h04; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        tick();
        chk("pre_rst_pending", {bvalid, rvalid}, 2'b11);
        rst = 1;
        tick(); tick();
        chk("mid_rst_ready", {awready, wready, arready}, 0);
        rst = 0;
        bad = 1'b0;
        repeat (5) begin
            tick();
            if (bvalid || rvalid) bad = 1'b1;
        end
        chk("no_resp_after_rst", bad, 0);
        chk("regs_reset_val", reg_q == c_RST, 1);
        chk("ready_after_rst", {awready, wready, arready}, 3'b111);

        // ---------------- 64-bit instance, 8-byte stride ------------------
        for (int i = 0; i < 4; i++) begin
            wr64(AW'(i * 8), {32'(i + 16), 32'(i + 1)}, resp);
            chk("w64_okay", resp, AXI_RESP_OKAY);
        end
        for (int i = 0; i < 4; i++) begin
            rd64(AW'(i * 8), d64, resp);
            chk("r64_data", d64, {32'(i + 16), 32'(i + 1)});
            chk("r64_okay", resp, AXI_RESP_OKAY);
        end
        chk("w64_reg3_q", reg_q_w[255:192], {32'd19, 32'd4});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
